// File: rtl/seq_response_mock.sv
// seq_response_mock
//   Clocked stand-in for a graded block. It counts the input changes it sees
//   on `inputs` and, for each change, drives a scripted value taken from a
//   response table that can be loaded at runtime.
//
// Ports
//   clk          rising-edge system clock
//   rst          asynchronous active-high reset (also clears the table)
//   inputs       monitored bus, sampled every clock edge
//   load_en      table write strobe
//   load_addr    table entry index (indices >= DEPTH are ignored)
//   load_data    table entry value
//   outputs      registered scripted response
//   change_count saturating count of detected input changes
//   seq_done     sticky flag, set when the DEPTH-th change is seen
//   primed       high once the baseline input sample has been taken
module seq_response_mock #(
    parameter int               IN_W        = 3,
    parameter int               OUT_W       = 1,
    parameter int               DEPTH       = 8,
    parameter int               CNT_W       = 16,
    parameter bit               WRAP        = 1'b0,
    parameter logic [OUT_W-1:0] DEFAULT_OUT = OUT_W'(1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IN_W-1:0]          inputs,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [OUT_W-1:0]         load_data,
    output logic [OUT_W-1:0]         outputs,
    output logic [CNT_W-1:0]         change_count,
    output logic                     seq_done,
    output logic                     primed
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    logic [IN_W-1:0]  prev_q;
    logic             primed_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             done_q, done_d;
    logic [OUT_W-1:0] table_q [DEPTH];

    logic             change;
    logic             table_we;

    // ptr_q holds the table index used by the most recent lookup, i.e.
    // (change_count-1) mod DEPTH. Tracking it incrementally avoids a modulo
    // on the counter. It starts at DEPTH-1 so the first change reads entry 0,
    // and it stops advancing once the counter saturates, which freezes the
    // replayed entry at (2^CNT_W-2) mod DEPTH.
    always_comb begin
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        out_d  = out_q;
        done_d = done_q;
        change = primed_q && (inputs != prev_q);

        if (change) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
                ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
            end
            // Lookup reads the registered table: a load to the same entry on
            // this edge only becomes visible to later lookups.
            if (WRAP || (32'(cnt_d) <= DEPTH)) begin
                out_d = table_q[ptr_d];
            end else begin
                out_d = DEFAULT_OUT;
            end
            if (32'(cnt_d) == DEPTH) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= LAST_IDX;
            out_q    <= DEFAULT_OUT;
            done_q   <= 1'b0;
        end else begin
            prev_q   <= inputs;
            primed_q <= 1'b1;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end

    assign table_we = load_en && (32'(load_addr) < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= DEFAULT_OUT;
            end
        end else if (table_we) begin
            table_q[load_addr] <= load_data;
        end
    end

    assign outputs      = out_q;
    assign change_count = cnt_q;
    assign seq_done     = done_q;
    assign primed       = primed_q;

endmodule

// File: tb/tb_seq_response_mock.sv
module tb_seq_response_mock;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_v;
    logic [2:0] le;
    logic [2:0] addr;
    logic [2:0] ld;

    logic        o0, o1, o2;
    logic [15:0] cc0, cc1;
    logic [2:0]  cc2;
    logic        sd0, sd1, sd2;
    logic        pr0, pr1, pr2;

    always #5 clk = ~clk;

    // inst0: DEPTH 7 hold mode; inst1: DEPTH 4 wrap; inst2: DEPTH 4 wrap, 3-bit counter
    seq_response_mock #(.IN_W(3), .OUT_W(1), .DEPTH(7), .CNT_W(16), .WRAP(1'b0), .DEFAULT_OUT(1'b1)) u0 (
        .clk(clk), .rst(rst), .inputs(in_v), .load_en(le[0]), .load_addr(addr),
        .load_data(ld[0]), .outputs(o0), .change_count(cc0), .seq_done(sd0), .primed(pr0));
    seq_response_mock #(.IN_W(3), .OUT_W(1), .DEPTH(4), .CNT_W(16), .WRAP(1'b1), .DEFAULT_OUT(1'b1)) u1 (
        .clk(clk), .rst(rst), .inputs(in_v), .load_en(le[1]), .load_addr(addr[1:0]),
        .load_data(ld[1]), .outputs(o1), .change_count(cc1), .seq_done(sd1), .primed(pr1));
    seq_response_mock #(.IN_W(3), .OUT_W(1), .DEPTH(4), .CNT_W(3), .WRAP(1'b1), .DEFAULT_OUT(1'b1)) u2 (
        .clk(clk), .rst(rst), .inputs(in_v), .load_en(le[2]), .load_addr(addr[1:0]),
        .load_data(ld[2]), .outputs(o2), .change_count(cc2), .seq_done(sd2), .primed(pr2));

    // Behavioural reference
    int         m_depth [3] = '{7, 4, 4};
    int         m_max   [3] = '{65535, 65535, 7};
    bit         m_wrap  [3] = '{1'b0, 1'b1, 1'b1};
    bit         m_tbl   [3][8];
    int         m_cnt   [3];
    bit         m_out   [3];
    bit         m_done  [3];
    bit         m_primed;
    logic [2:0] m_prev;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 8; a++) m_tbl[k][a] = 1'b1;
            m_cnt[k]  = 0;
            m_out[k]  = 1'b1;
            m_done[k] = 1'b0;
        end
        m_primed = 1'b0;
        m_prev   = '0;
    endtask

    task automatic model_edge(input logic [2:0] iv, input logic [2:0] lev,
                              input logic [2:0] a, input logic [2:0] d);
        bit chg;
        int n;
        chg = m_primed && (iv != m_prev);
        for (int k = 0; k < 3; k++) begin
            if (chg) begin
                n = (m_cnt[k] + 1 > m_max[k]) ? m_max[k] : m_cnt[k] + 1;
                if (m_wrap[k] || n <= m_depth[k]) m_out[k] = m_tbl[k][(n - 1) % m_depth[k]];
                else                              m_out[k] = 1'b1;
                if (n == m_depth[k]) m_done[k] = 1'b1;
                m_cnt[k] = n;
            end
            if (lev[k] && int'(a) < m_depth[k]) m_tbl[k][a] = d[k];
        end
        m_prev   = iv;
        m_primed = 1'b1;
    endtask

    task automatic check_all();
        chk("out0", int'(o0), int'(m_out[0]));
        chk("cnt0", int'(cc0), m_cnt[0]);
        chk("done0", int'(sd0), int'(m_done[0]));
        chk("primed0", int'(pr0), int'(m_primed));
        chk("out1", int'(o1), int'(m_out[1]));
        chk("cnt1", int'(cc1), m_cnt[1]);
        chk("done1", int'(sd1), int'(m_done[1]));
        chk("primed1", int'(pr1), int'(m_primed));
        chk("out2", int'(o2), int'(m_out[2]));
        chk("cnt2", int'(cc2), m_cnt[2]);
        chk("done2", int'(sd2), int'(m_done[2]));
        chk("primed2", int'(pr2), int'(m_primed));
    endtask

    task automatic step(input logic [2:0] iv, input logic [2:0] lev,
                        input logic [2:0] a, input logic [2:0] d);
        in_v = iv; le = lev; addr = a; ld = d;
        @(posedge clk);
        model_edge(iv, lev, a, d);
        #1;
        check_all();
        le = '0;
    endtask

    // Asynchronous reset asserted mid-cycle, checked before the next edge
    task automatic mid_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_out0", int'(o0), 1);
        chk("rst_cnt0", int'(cc0), 0);
        chk("rst_primed0", int'(pr0), 0);
        #1 rst = 1'b0;
    endtask

    bit         t0 [7]  = '{0, 1, 1, 1, 0, 1, 0};
    bit         t1 [4]  = '{0, 1, 0, 1};
    bit         t2 [4]  = '{0, 1, 1, 0};
    bit         x0 [10] = '{0, 1, 1, 1, 0, 1, 0, 1, 1, 1};
    bit         x1 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    bit         x2 [10] = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    logic [2:0] cur;
    logic [2:0] iv, lv, av, dv;

    initial begin
        rst = 1'b1; in_v = '0; le = '0; addr = '0; ld = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        #2 rst = 1'b0;

        // Table loads on the priming edge onward; baseline 3'b101 never counts
        cur = 3'b101;
        for (int i = 0; i < 7; i++) begin
            lv = {(i < 4) ? 1'b1 : 1'b0, (i < 4) ? 1'b1 : 1'b0, 1'b1};
            dv = {(i < 4) ? t2[i] : 1'b0, (i < 4) ? t1[i] : 1'b0, t0[i]};
            step(cur, lv, 3'(i), dv);
        end
        step(cur, 3'b001, 3'd7, 3'b000);   // out-of-range address on inst0
        for (int i = 0; i < 20; i++) step(cur, '0, '0, '0);
        chk("hold_cnt0", int'(cc0), 0);
        chk("hold_out0", int'(o0), 1);
        chk("hold_done0", int'(sd0), 0);
        chk("hold_primed0", int'(pr0), 1);

        // Ten distinct successive changes; inst2 rewrites entry 2 on change 3
        for (int i = 1; i <= 10; i++) begin
            cur = cur ^ 3'($urandom_range(1, 7));
            if (i == 3) step(cur, 3'b100, 3'd2, 3'b000);
            else        step(cur, '0, '0, '0);
            chk("lit_out0", int'(o0), int'(x0[i-1]));
            chk("lit_out1", int'(o1), int'(x1[i-1]));
            chk("lit_out2", int'(o2), int'(x2[i-1]));
            chk("lit_cnt0", int'(cc0), i);
            chk("lit_cnt2", int'(cc2), (i > 7) ? 7 : i);
            chk("lit_done0", int'(sd0), (i >= 7) ? 1 : 0);
            chk("lit_done1", int'(sd1), (i >= 4) ? 1 : 0);
        end

        // Reset, re-prime without counting, three changes, reset mid-cycle
        mid_reset();
        cur = 3'b010;
        step(cur, '0, '0, '0);
        chk("reprime_cnt0", int'(cc0), 0);
        chk("reprime_primed0", int'(pr0), 1);
        for (int i = 0; i < 3; i++) begin
            cur = cur ^ 3'($urandom_range(1, 7));
            step(cur, '0, '0, '0);
        end
        chk("pre_rst_cnt0", int'(cc0), 3);
        mid_reset();

        // Randomized traffic with loads and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) cur = 3'($urandom_range(0, 7));
            av = 3'($urandom_range(0, 7));
            lv = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(0, 7)) : 3'b000;
            if (av >= 3'd4) lv[2:1] = 2'b00;
            dv = 3'($urandom_range(0, 7));
            step(cur, lv, av, dv);
            if ($urandom_range(0, 59) == 0) mid_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
